count2bit_decoder: RTL

//  Consumer end of the 2-bit up/down count interface: samples a free-running 2-bit count

---
 rtl/count2bit_pkg.sv | 24 ++
 rtl/sat_counter.sv | 34 +++
 rtl/count2bit_decoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/count2bit_pkg.sv
// Shared types and the step classifier for the 2-bit count stream decoder.
package count2bit_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } dec_state_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_SKIP = 2'd2,
    STEP_DOWN = 2'd3
  } step_t;

  // Modulo-4 difference maps directly onto the step encoding.
  function automatic step_t classify_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] delta;
    delta = cur - prev;
    return step_t'(delta);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_value;
  logic [W-1:0] w_value;

  always_comb begin
    w_value = r_value;
    if (i_clr) begin
      w_value = '0;
    end else if (i_inc && (r_value != '1)) begin
      w_value = r_value + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else begin
      r_value <= w_value;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/count2bit_decoder.sv
// Decodes a sampled 2-bit up/down count stream into position steps, tracks lock
// against the commanded direction and counts direction/skip errors.
module count2bit_decoder
  import count2bit_pkg::*;
#(
  parameter int unsigned POS_W    = 16,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned SYNC_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [1:0]       count_in,
  input  logic             up_down,
  output logic [POS_W-1:0] position,
  output logic             dir_out,
  output logic             step_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             skip_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0]       SyncReq = 4'(SYNC_REQ);
  localparam logic [POS_W-1:0] PosOne  = POS_W'(1);

  dec_state_t       r_state, w_state;
  logic [1:0]       r_prev, w_prev;
  logic [3:0]       r_good_cnt, w_good_cnt;
  logic [POS_W-1:0] r_position, w_position;
  logic             r_dir, w_dir;
  logic             r_step_valid, w_step_valid;
  logic             r_mismatch, w_mismatch;
  logic             r_skip_err, w_skip_err;
  logic             w_err_inc;
  step_t            w_step;
  logic             w_is_up;

  always_comb begin
    w_state      = r_state;
    w_prev       = r_prev;
    w_good_cnt   = r_good_cnt;
    w_position   = r_position;
    w_dir        = r_dir;
    w_step_valid = 1'b0;
    w_mismatch   = 1'b0;
    w_skip_err   = 1'b0;
    w_err_inc    = 1'b0;
    w_step       = classify_step(r_prev, count_in);
    w_is_up      = (w_step == STEP_UP);

    if (sample_en) begin
      w_prev = count_in;
      case (r_state)
        UNLOCKED: begin
          w_state    = ACQUIRE;
          w_good_cnt = '0;
        end
        ACQUIRE: begin
          case (w_step)
            STEP_UP, STEP_DOWN: begin
              if (w_is_up == up_down) begin
                if (r_good_cnt + 4'd1 >= SyncReq) begin
                  w_state    = LOCKED;
                  w_good_cnt = '0;
                end else begin
                  w_good_cnt = r_good_cnt + 4'd1;
                end
              end else begin
                w_good_cnt = '0;
              end
            end
            STEP_SKIP: w_good_cnt = '0;
            default: ;
          endcase
        end
        LOCKED: begin
          case (w_step)
            STEP_UP, STEP_DOWN: begin
              w_position   = w_is_up ? r_position + PosOne : r_position - PosOne;
              w_dir        = w_is_up;
              w_step_valid = 1'b1;
              // Position follows the observed step even when it disagrees with the command.
              if (w_is_up != up_down) begin
                w_mismatch = 1'b1;
                w_err_inc  = 1'b1;
              end
            end
            STEP_SKIP: begin
              w_skip_err = 1'b1;
              w_err_inc  = 1'b1;
              w_state    = ACQUIRE;
              w_good_cnt = '0;
            end
            default: ;
          endcase
        end
        default: begin
          w_state    = UNLOCKED;
          w_good_cnt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= UNLOCKED;
      r_prev       <= '0;
      r_good_cnt   <= '0;
      r_position   <= '0;
      r_dir        <= 1'b0;
      r_step_valid <= 1'b0;
      r_mismatch   <= 1'b0;
      r_skip_err   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_prev       <= w_prev;
      r_good_cnt   <= w_good_cnt;
      r_position   <= w_position;
      r_dir        <= w_dir;
      r_step_valid <= w_step_valid;
      r_mismatch   <= w_mismatch;
      r_skip_err   <= w_skip_err;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_err_inc),
    .i_clr  (1'b0),
    .o_value(err_count)
  );

  assign position   = r_position;
  assign dir_out    = r_dir;
  assign step_valid = r_step_valid;
  assign locked     = (r_state == LOCKED);
  assign mismatch   = r_mismatch;
  assign skip_err   = r_skip_err;

endmodule
